// File: rtl/uart_rx_pkg.sv
// Shared widths, default sizing and the stored entry layout for the UART receive buffer.
package uart_rx_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int RX_ENTRY_W     = 9;
    localparam int RX_FIFO_DEPTH  = 16;
    localparam int RX_FIFO_THRESH = 8;
    localparam int PERR_BIT       = 8;

    // Parity-error flag sits above the data byte, at PERR_BIT.
    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] dat;
    } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x W storage: synchronous write, asynchronous read; contents are not reset.
// Latency: write visible on the read port the cycle after the write edge. No backpressure.
// Pointers and flow control live in the wrapper.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdat
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdat;
        end
    end

    assign rdat = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one entry per rx_int rising edge, FWFT read port, overrun/irq status.
// Latency: entry readable and count/flags updated the cycle after the push edge; irq registered.
// Backpressure: none upstream; push while full without a pop drops the frame and sets sticky ovr.
// Optional receive timeout enabled by defining RX_TIMEOUT_EN.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH     = RX_FIFO_DEPTH,
    parameter int THRESH    = RX_FIFO_THRESH,
    parameter int TO_CYCLES = 640
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [UART_DATA_W-1:0]   rx_dat,
    input  logic                     rx_err,
    input  logic                     rx_int,
    input  logic                     rd_en,
    output logic [UART_DATA_W-1:0]   rd_dat,
    output logic                     rd_perr,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovr,
    input  logic                     ovr_clr,
    output logic                     rx_to,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  ovr_q, ovr_d, irq_q, irq_d;
    logic                  rx_int_q, rx_int_d;
    logic                  push, pop, wr_en, ovf;
    logic                  rx_to_nxt;
    rx_entry_t             wr_entry;
    logic [RX_ENTRY_W-1:0] rd_entry;

    always_comb begin
        rx_int_d = rx_int;
        push     = rx_int & ~rx_int_q;
        pop      = rd_en & ~empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        wr_en    = push & (~full_q | pop);
        ovf      = push & full_q & ~pop;
        wr_entry = '{perr: rx_err, dat: rx_dat};

        wptr_d   = wr_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = pop   ? rptr_q + AW'(1) : rptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CW'(DEPTH));
        // Set beats clear when both land in the same cycle.
        ovr_d    = (ovr_q & ~ovr_clr) | ovf;
        irq_d    = (count_d >= CW'(THRESH)) | ovr_d | rx_to_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
            rx_int_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
            rx_int_q <= rx_int_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rx_to_q, rx_to_d;

    // Idle timer over a non-empty FIFO; any traffic restarts it and drops the flag.
    always_comb begin
        to_cnt_d = to_cnt_q;
        rx_to_d  = rx_to_q;
        if (push | pop) begin
            to_cnt_d = '0;
            rx_to_d  = 1'b0;
        end else if (empty_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
            rx_to_d  = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            rx_to_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            rx_to_q  <= rx_to_d;
        end
    end

    assign rx_to_nxt = rx_to_d;
    assign rx_to     = rx_to_q;
`else
    assign rx_to_nxt = 1'b0;
    assign rx_to     = 1'b0;
`endif

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (RX_ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q),
        .wdat  (wr_entry),
        .raddr (rptr_q),
        .rdat  (rd_entry)
    );

    // Head is masked while empty so stale RAM never reaches the CPU.
    assign rd_dat  = empty_q ? '0   : rd_entry[UART_DATA_W-1:0];
    assign rd_perr = empty_q ? 1'b0 : rd_entry[PERR_BIT];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;
    assign ovr     = ovr_q;
    assign irq     = irq_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver. Each completed frame is taken from the receiver's byte/error/done outputs on the rising edge of its done pulse. The byte and its parity-error flag are stored in a power-of-two FIFO. The FIFO is presented to the CPU side as a first-word-fall-through read port with count, overrun and interrupt status.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
THRESH, 8, fill level (1..DEPTH) at which irq asserts.
TO_CYCLES, 640, idle clk cycles before the timeout flag sets (only used with RX_TIMEOUT_EN).

Ports:
clk  in  1  clock, same domain as the receiver.
rst  in  1  reset, asynchronous, active-high.
rx_dat  in  8  received byte from the receiver.
rx_err  in  1  parity error for rx_dat.
rx_int  in  1  receiver frame-done level; held high for several cycles per frame.
rd_en  in  1  pop head entry.
rd_dat  out  8  head entry data; valid when empty=0.
rd_perr  out  1  head entry parity-error bit.
empty  out  1  FIFO holds 0 entries.
full  out  1  FIFO holds DEPTH entries.
count  out  $clog2(DEPTH)+1  number of entries held.
ovr  out  1  sticky overrun flag.
ovr_clr  in  1  clears ovr.
rx_to  out  1  receive-timeout flag.
irq  out  1  registered interrupt request.

Behaviour:
- Reset values: all pointers 0, count=0, empty=1, full=0, ovr=0, rx_to=0, irq=0, rx_int_q=0. rd_dat and rd_perr are 0 while empty after reset.
- Push detect: register rx_int into rx_int_q. push = rx_int & ~rx_int_q.
  - Exactly one push per frame, however long rx_int stays high.
  - rx_dat and rx_err are sampled in the push cycle.
- Storage entry is {rx_err, rx_dat}, 9 bits. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Read is FWFT:
  - rd_dat and rd_perr combinationally show mem[rptr].
  - rd_en with empty=0 advances rptr at the next clk edge, so the next entry appears in the following cycle.
  - rd_en with empty=1 is ignored; no pointer change, no error.
- Simultaneous events:
  - push & valid pop, not full, not empty: both occur; count unchanged.
  - push & rd_en while empty: push accepted, rd_en ignored; count goes to 1.
  - push & valid pop while full: both occur; count stays DEPTH; no overrun.
  - push while full with no pop: entry dropped, memory and pointers untouched, ovr set to 1.
- ovr is sticky and cleared by ovr_clr. If ovr_clr and a new overrun happen in the same cycle, set wins.
- count/full/empty are registered from the pointer update; they change in the cycle after the push or pop edge.
- irq (registered) = (count_next >= THRESH) | ovr_next | rx_to_next.
- Reset mid-frame or mid-read: all state returns to reset values immediately; FIFO contents are discarded.

Optional Feature:
RX_TIMEOUT_EN:
- Defined: a timeout counter runs only while empty=0.
  - Reset to 0 on any push or valid pop.
  - When it reaches TO_CYCLES-1, rx_to sets and the counter holds.
  - rx_to clears on the next valid pop or push.
  - Purpose: flushes partial packets below THRESH to the CPU.
- Undefined: no counter logic; rx_to is tied 0 and irq ignores it.

Decomposition:
- Package uart_rx_pkg holds:
  - UART_DATA_W=8
  - RX_ENTRY_W=9
  - default RX_FIFO_DEPTH=16
  - default RX_FIFO_THRESH=8
  - the rx entry struct/bit positions (PERR_BIT=8)
- One sub-module, uart_fifo_ram: DEPTH x RX_ENTRY_W storage with a synchronous write port and an asynchronous read port. The wrapper owns pointers, flags and irq.

Test Plan:
- Single frame: rx_dat=0xA5, rx_err=0, rx_int high 20 cycles -> exactly one entry; count=1; rd_dat=0xA5, rd_perr=0. rd_en for one cycle -> empty=1.
- Parity flag: rx_dat=0x3C, rx_err=1 -> rd_perr=1 with rd_dat=0x3C. The following frame 0x3D with rx_err=0 -> rd_perr=0.
- Fill/overrun: 16 frames 0x00..0x0F -> full=1, irq=1 once count reaches 8. A 17th frame 0xFF -> ovr=1, count=16, and reads return 0x00..0x0F in order. Pulse ovr_clr -> ovr=0.
- Wrap and simultaneous: keep 4 entries queued while streaming 40 frames with a pop on every push cycle -> data order is preserved across pointer wrap and count stays 4. Push+pop while full -> no ovr.
- Reset mid-operation: 5 entries queued, assert rst for 1 cycle -> count=0, empty=1, irq=0, ovr=0. A post-reset frame 0x5A reads back correctly.
- RX_TIMEOUT_EN (TO_CYCLES=640): 2 frames, no reads -> rx_to=1 and irq=1 exactly 640 cycles after the last push. One pop -> rx_to=0. Without the macro, rx_to stays 0.
